io_bus_ctrl: RTL and testbench
==============================

Name: io_bus_ctrl

Overview:
- Parametrised successor to the CPU-side IO address/data register pair.
- Holds the IO address and write-data registers, loaded from the primary and secondary buses, as before.
- Adds a transaction sequencer: on a start pulse it drives a read or write strobe onto the IO bus and waits for the device ack, with a timeout.
- On a read, captures the returned data for the CPU. Sits between the CPU datapath and IO devices.

Parameters:
- DATA_W, 16, IO data width (io_data, io_rdata, rd_data).
- ADDR_W, 8, IO address width; taken from the LSBs of the address buses.
- BUS_W, 16, CPU bus width; must be >= DATA_W and >= ADDR_W.
- TIMEOUT, 255, max cycles to wait for io_ack before aborting; must be >= 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- data_bus  in  BUS_W  write-data source
- data_we  in  1  load io_data from data_bus[DATA_W-1:0]
- addrs_bus  in  BUS_W  primary address source
- addrs_we  in  1  load io_addr from addrs_bus[ADDR_W-1:0]
- addrs_sec_bus  in  BUS_W  secondary address source
- addrs_sec_we  in  1  load io_addr from addrs_sec_bus[ADDR_W-1:0]
- start_wr  in  1  pulse: begin write transaction
- start_rd  in  1  pulse: begin read transaction
- io_ack  in  1  device acknowledge
- io_rdata  in  DATA_W  device read data, valid with io_ack
- io_data  out  DATA_W  write-data register
- io_addr  out  ADDR_W  address register
- io_wr_stb  out  1  write strobe, held until ack or timeout
- io_rd_stb  out  1  read strobe, held until ack or timeout
- busy  out  1  transaction in progress
- rd_data  out  DATA_W  last captured read data
- rd_valid  out  1  one-cycle pulse when rd_data updates
- timeout_err  out  1  sticky: last transaction timed out

Behaviour:
- Reset (async): every output and register is 0, and the FSM is IDLE.
- FSM states are IDLE, WR, RD; all outputs are registered.
- Register loads:
  - Loads are accepted only when busy=0; while busy they are ignored.
  - If addrs_we and addrs_sec_we fire in the same cycle, addrs_sec_bus wins.
  - data_we is independent of the address loads.
- IDLE:
  - start_wr -> WR next cycle.
  - start_rd -> RD next cycle.
  - If both fire together, WR wins and start_rd is dropped.
  - Any start clears timeout_err.
  - Register loads in the same cycle as a start are accepted and used by that transaction.
- WR / RD:
  - Assert the strobe (io_wr_stb or io_rd_stb) and busy starting the cycle after the start; wait counter starts at 0.
  - The strobe is high for at least 1 cycle; io_ack is sampled only in WR/RD.
  - io_ack in RD: rd_data <= io_rdata and rd_valid=1 for one cycle.
  - io_ack in either state: drop the strobe and go to IDLE next cycle.
  - Starts arriving while busy are ignored.
- Timeout:
  - Wait counter increments each cycle in WR/RD without ack.
  - When it reaches TIMEOUT-1 with no ack: go to IDLE, drop the strobe, set timeout_err=1.
  - rd_data is unchanged on a timeout and no rd_valid pulse is generated.
  - Ack on the final counting cycle counts as success.
- Latency: start -> strobe is 1 cycle; ack -> busy=0 and rd_valid pulse is 1 cycle.
- Reset asserted mid-transaction: strobes drop immediately (async) and the transaction is lost.

Optional Feature:
- Macro: IO_BUS_CTRL_AUTOINC_EN.
- Defined: after each acked transaction, io_addr <= io_addr+1, wrapping mod 2^ADDR_W. This happens on the same edge the FSM returns to IDLE. No increment on timeout.
- Undefined: io_addr changes only via addrs_we / addrs_sec_we.

Decomposition:
- Package io_bus_pkg:
  - FSM state enum (IDLE, WR, RD).
  - Default width constants (DATA_W=16, ADDR_W=8, BUS_W=16).
  - Default TIMEOUT.
- Sub-module io_wait_timer:
  - Clear/enable counter of width $clog2(TIMEOUT+1).
  - Outputs an expired flag at count TIMEOUT-1.

Test Plan:
- Reset mid-WR with io_wr_stb=1 -> all outputs 0 asynchronously, before the next clock edge.
- addrs_we=1 (addrs_bus=0x1234) together with addrs_sec_we=1 (addrs_sec_bus=0x00AB) -> io_addr=0xAB next cycle.
- data_we with 0xBEEF, then start_wr; io_ack 3 cycles after the strobe rises -> io_data=0xBEEF throughout; strobe high 3 cycles; busy drops the cycle after ack; timeout_err=0.
- start_rd, io_ack with io_rdata=0x5A5A -> rd_data=0x5A5A, rd_valid high exactly 1 cycle; data_we=1 pulsed while busy -> io_data unchanged.
- start_rd with no ack, TIMEOUT=4 -> strobe high 4 cycles, then timeout_err=1, rd_data unchanged; next start_wr clears timeout_err.
- AUTOINC_EN with io_addr=0xFF: acked write -> io_addr=0x00; then timed-out read -> io_addr stays 0x00. start_wr and start_rd together -> only io_wr_stb asserts.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and default widths for the IO bus controller and its wait timer.
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } io_state_t;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_BUS_W   = 16;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/io_wait_timer.sv
// Clear/enable wait counter; expired is high while the count sits at TIMEOUT-1.
module io_wait_timer
    import io_bus_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/io_bus_ctrl.sv
// IO address/write-data registers plus a strobe/ack transaction sequencer with timeout.
// Optional build macro IO_BUS_CTRL_AUTOINC_EN: post-increment io_addr after each acked transaction.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BUS_W   = DEF_BUS_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_W-1:0]  data_bus,
    input  logic              data_we,
    input  logic [BUS_W-1:0]  addrs_bus,
    input  logic              addrs_we,
    input  logic [BUS_W-1:0]  addrs_sec_bus,
    input  logic              addrs_sec_we,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic              io_ack,
    input  logic [DATA_W-1:0] io_rdata,
    output logic [DATA_W-1:0] io_data,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_wr_stb,
    output logic              io_rd_stb,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              timeout_err
);

    io_state_t state;
    logic      expired;

    // Only the low bits of the CPU buses are used.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{data_bus, addrs_bus, addrs_sec_bus};

    io_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .en      ((state != IDLE) && !io_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            io_data     <= '0;
            io_addr     <= '0;
            io_wr_stb   <= 1'b0;
            io_rd_stb   <= 1'b0;
            busy        <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Loads are only taken while idle; secondary address source has priority.
                    if (addrs_sec_we) begin
                        io_addr <= addrs_sec_bus[ADDR_W-1:0];
                    end else if (addrs_we) begin
                        io_addr <= addrs_bus[ADDR_W-1:0];
                    end
                    if (data_we) begin
                        io_data <= data_bus[DATA_W-1:0];
                    end
                    if (start_wr) begin
                        state       <= WR;
                        io_wr_stb   <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end else if (start_rd) begin
                        state       <= RD;
                        io_rd_stb   <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                WR, RD: begin
                    // Ack is checked before expiry so an ack on the last cycle still succeeds.
                    if (io_ack) begin
                        state     <= IDLE;
                        io_wr_stb <= 1'b0;
                        io_rd_stb <= 1'b0;
                        busy      <= 1'b0;
                        if (state == RD) begin
                            rd_data  <= io_rdata;
                            rd_valid <= 1'b1;
                        end
`ifdef IO_BUS_CTRL_AUTOINC_EN
                        io_addr <= io_addr + 1'b1;
`else
                        io_addr <= io_addr;
`endif
                    end else if (expired) begin
                        state       <= IDLE;
                        io_wr_stb   <= 1'b0;
                        io_rd_stb   <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    io_wr_stb <= 1'b0;
                    io_rd_stb <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl with TIMEOUT=4; honours IO_BUS_CTRL_AUTOINC_EN if defined.
module tb_io_bus_ctrl;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int BUS_W   = 16;
    localparam int TIMEOUT = 4;
`ifdef IO_BUS_CTRL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [BUS_W-1:0]  data_bus, addrs_bus, addrs_sec_bus;
    logic              data_we, addrs_we, addrs_sec_we;
    logic              start_wr, start_rd, io_ack;
    logic [DATA_W-1:0] io_rdata;
    logic [DATA_W-1:0] io_data, rd_data;
    logic [ADDR_W-1:0] io_addr;
    logic              io_wr_stb, io_rd_stb, busy, rd_valid, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    io_bus_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUS_W(BUS_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .data_bus(data_bus), .data_we(data_we),
        .addrs_bus(addrs_bus), .addrs_we(addrs_we),
        .addrs_sec_bus(addrs_sec_bus), .addrs_sec_we(addrs_sec_we),
        .start_wr(start_wr), .start_rd(start_rd),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .io_data(io_data), .io_addr(io_addr),
        .io_wr_stb(io_wr_stb), .io_rd_stb(io_rd_stb),
        .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".io_data"}, io_data, 0);
        check({tag, ".io_addr"}, io_addr, 0);
        check({tag, ".io_wr_stb"}, io_wr_stb, 0);
        check({tag, ".io_rd_stb"}, io_rd_stb, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".rd_data"}, rd_data, 0);
        check({tag, ".rd_valid"}, rd_valid, 0);
        check({tag, ".timeout_err"}, timeout_err, 0);
    endtask

    // Counts strobe-high cycles after the start edge until the strobe drops (bounded).
    task automatic wait_strobe_drop(output int cycles);
        cycles = 0;
        while ((io_wr_stb || io_rd_stb) && cycles < 20) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_addr;
        int n;

        rst = 1'b1;
        data_bus = '0; addrs_bus = '0; addrs_sec_bus = '0;
        data_we = 0; addrs_we = 0; addrs_sec_we = 0;
        start_wr = 0; start_rd = 0; io_ack = 0; io_rdata = '0;
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Simultaneous address loads: secondary wins.
        addrs_bus = 16'h1234; addrs_we = 1;
        addrs_sec_bus = 16'h00AB; addrs_sec_we = 1;
        tick();
        addrs_we = 0; addrs_sec_we = 0;
        check("addr_sec_wins", io_addr, 8'hAB);
        addrs_we = 1;
        tick();
        addrs_we = 0;
        check("addr_primary", io_addr, 8'h34);
        exp_addr = 8'h34;

        // Write transaction, ack on the third strobe cycle.
        data_bus = 16'hBEEF; data_we = 1;
        tick();
        data_we = 0;
        check("wdata_load", io_data, 16'hBEEF);
        start_wr = 1;
        tick();
        start_wr = 0;
        check("wr_stb_c1", io_wr_stb, 1);
        check("wr_busy_c1", busy, 1);
        check("wr_rdstb_c1", io_rd_stb, 0);
        tick();
        check("wr_stb_c2", io_wr_stb, 1);
        tick();
        check("wr_stb_c3", io_wr_stb, 1);
        io_ack = 1;
        tick();
        io_ack = 0;
        if (AUTOINC) exp_addr = exp_addr + 1'b1;
        check("wr_stb_done", io_wr_stb, 0);
        check("wr_busy_done", busy, 0);
        check("wr_tmo", timeout_err, 0);
        check("wr_rd_valid", rd_valid, 0);
        check("wr_io_data", io_data, 16'hBEEF);
        check("wr_addr_after", io_addr, exp_addr);

        // Read transaction with a write-data load attempted while busy.
        start_rd = 1;
        tick();
        start_rd = 0;
        check("rd_stb_c1", io_rd_stb, 1);
        check("rd_busy_c1", busy, 1);
        data_bus = 16'h1111; data_we = 1;
        tick();
        data_we = 0;
        check("rd_load_ignored", io_data, 16'hBEEF);
        io_ack = 1; io_rdata = 16'h5A5A;
        tick();
        io_ack = 0; io_rdata = 16'h0000;
        if (AUTOINC) exp_addr = exp_addr + 1'b1;
        check("rd_data", rd_data, 16'h5A5A);
        check("rd_valid_pulse", rd_valid, 1);
        check("rd_busy_done", busy, 0);
        check("rd_stb_done", io_rd_stb, 0);
        tick();
        check("rd_valid_one_cycle", rd_valid, 0);
        check("rd_data_hold", rd_data, 16'h5A5A);
        check("rd_io_data_after", io_data, 16'hBEEF);

        // Read timeout: strobe high TIMEOUT cycles then sticky error.
        start_rd = 1;
        tick();
        start_rd = 0;
        check("tmo_err_early", timeout_err, 0);
        wait_strobe_drop(n);
        check("tmo_stb_cycles", n, TIMEOUT);
        check("tmo_err_set", timeout_err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_rd_data", rd_data, 16'h5A5A);
        check("tmo_rd_valid", rd_valid, 0);
        check("tmo_addr", io_addr, exp_addr);
        tick();
        check("tmo_err_sticky", timeout_err, 1);

        // Next start clears the error.
        start_wr = 1;
        tick();
        start_wr = 0;
        check("clr_tmo", timeout_err, 0);
        check("clr_wr_stb", io_wr_stb, 1);
        io_ack = 1;
        tick();
        io_ack = 0;
        if (AUTOINC) exp_addr = exp_addr + 1'b1;
        check("clr_done", busy, 0);

        // Wrap at 0xFF: acked write then timed-out read.
        addrs_bus = 16'h00FF; addrs_we = 1;
        tick();
        addrs_we = 0;
        exp_addr = 8'hFF;
        check("wrap_load", io_addr, exp_addr);
        start_wr = 1;
        tick();
        start_wr = 0;
        io_ack = 1;
        tick();
        io_ack = 0;
        if (AUTOINC) exp_addr = exp_addr + 1'b1;
        check("wrap_ack_addr", io_addr, exp_addr);
        start_rd = 1;
        tick();
        start_rd = 0;
        wait_strobe_drop(n);
        check("wrap_tmo_cycles", n, TIMEOUT);
        check("wrap_tmo_addr", io_addr, exp_addr);

        // Both starts together: write wins, read dropped; starts while busy ignored.
        start_wr = 1; start_rd = 1;
        tick();
        start_wr = 0; start_rd = 0;
        check("both_wr_stb", io_wr_stb, 1);
        check("both_rd_stb", io_rd_stb, 0);
        start_rd = 1;
        tick();
        start_rd = 0;
        check("busy_start_ignored", io_rd_stb, 0);
        io_ack = 1;
        tick();
        io_ack = 0;
        tick();
        check("both_rd_dropped", io_rd_stb, 0);
        check("both_idle", busy, 0);

        // Asynchronous reset mid-write.
        start_wr = 1;
        tick();
        start_wr = 0;
        check("async_pre_stb", io_wr_stb, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
